// File: rtl/fx_boxmuller_radius.sv
// Box-Muller radius stage: r = floor(sqrt(-2*ln_in)) in the input Q format,
// computed by a restoring digit-by-digit square root, one root bit per clock.

package fpga_cfg_pkg;
  localparam int FP_WIDTH = 32;
  localparam int FP_QFRAC = 16;
endpackage

module fx_boxmuller_radius
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QFRAC = FP_QFRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] ln_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] r_out,
  output logic             sat_out
);

  localparam int ITER  = (WIDTH + QFRAC + 1) / 2;
  localparam int RAD_W = 2 * ITER;
  localparam int REM_W = ITER + 2;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [WIDTH:0] SAT_LIM = (WIDTH + 1)'(1) << (WIDTH - 2);

  // Handshake: a transfer occurs on any rising edge where valid and ready are
  // both high; valid_out is a pure state decode and never looks at ready_in.
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [RAD_W-1:0]   rad;
  logic [REM_W-1:0]   rem;
  logic [ITER-1:0]    root;
  logic [CNT_W-1:0]   cnt;
  logic               sat_q;

  logic [WIDTH:0]     neg_ln;
  logic [WIDTH-1:0]   x;
  logic               sat_nxt;
  logic [RAD_W-1:0]   rad_init;
  logic [REM_W+1:0]   rem_sh;
  logic [REM_W+1:0]   trial;
  logic               ge;
  logic               accept;
  logic               last_step;

  // Operand formation: -2*ln clamped to the largest positive WIDTH-bit value.
  assign neg_ln = -{ln_in[WIDTH-1], ln_in};

  always_comb begin
    x       = '0;
    sat_nxt = 1'b0;
    if (!ln_in[WIDTH-1]) begin
      sat_nxt = |ln_in;
    end else if (neg_ln >= SAT_LIM) begin
      x       = {1'b0, {(WIDTH-1){1'b1}}};
      sat_nxt = 1'b1;
    end else begin
      x = {neg_ln[WIDTH-2:0], 1'b0};
    end
  end

  assign rad_init = RAD_W'({x, {QFRAC{1'b0}}});

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  assign rem_sh = {rem, rad[RAD_W-1 -: 2]};
  assign trial  = {2'b00, root, 2'b01};
  assign ge     = (rem_sh >= trial);

  assign accept    = valid_in && (state == IDLE);
  assign last_step = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in)  state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (ready_in)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state == IDLE);
    valid_out = (state == DONE);
    r_out     = (state == DONE) ? WIDTH'(root) : '0;
    sat_out   = (state == DONE) && sat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad   <= '0;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      rad   <= rad_init;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
      sat_q <= sat_nxt;
    end else if (state == CALC) begin
      rad  <= rad << 2;
      rem  <= ge ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
      root <= {root[ITER-2:0], ge};
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule
